// File: rtl/maxpool_pkg.sv
// Shared types for the max/min pooling command engine: opcodes, FSM states
// and the queued command record.
package maxpool_pkg;

  localparam int MP_ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_MAX2  = 2'b00,
    OP_MIN2  = 2'b01,
    OP_ACC   = 2'b10,
    OP_FLUSH = 2'b11
  } maxpool_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_CMP  = 2'b10,
    ST_WB   = 2'b11
  } maxpool_state_e;

  typedef struct packed {
    maxpool_op_e          op;
    logic [MP_ADDR_W-1:0] src1;
    logic [MP_ADDR_W-1:0] src2;
    logic [MP_ADDR_W-1:0] dst;
  } maxpool_cmd_t;

endpackage

// File: rtl/maxpool_cmd_fifo.sv
// Synchronous command queue; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module maxpool_cmd_fifo
  import maxpool_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  maxpool_cmd_t     wdata,
  input  logic             pop,
  output maxpool_cmd_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  maxpool_cmd_t   mem [DEPTH];
  logic [PTR_W:0] wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                 (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
  assign level = wptr - rptr;
  assign rdata = mem[rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/maxpool_unit.sv
// Multi-lane signed max/min command engine with running pooling accumulator.
// MAXPOOL_MIN_EN enables op 01 (MIN2); otherwise op 01 is dropped as illegal.
module maxpool_unit
  import maxpool_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int LANES      = 4,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_W-1:0]         cmd_src1,
  input  logic [ADDR_W-1:0]         cmd_src2,
  input  logic [ADDR_W-1:0]         cmd_dst,
  output logic [ADDR_W-1:0]         rf_raddr1,
  output logic [ADDR_W-1:0]         rf_raddr2,
  input  logic [LANES*DATA_W-1:0]   rf_rdata1,
  input  logic [LANES*DATA_W-1:0]   rf_rdata2,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [LANES*DATA_W-1:0]   rf_wdata,
  output logic                      busy,
  output logic                      err_illegal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  maxpool_state_e state, state_nx;
  maxpool_cmd_t   push_cmd, head;
  logic           push, pop, full, empty, illegal, avail;
  logic [PTR_W:0] level;

  maxpool_op_e                    op_q;
  logic [ADDR_W-1:0]              dst_q, raddr1_q, raddr2_q, waddr_q;
  logic [LANES-1:0][DATA_W-1:0]   wdata_q, acc_q, res;
  logic                           acc_valid;

  assign push          = cmd_valid && !full;
  assign cmd_ready     = !full;
  assign push_cmd.op   = maxpool_op_e'(cmd_op);
  assign push_cmd.src1 = MP_ADDR_W'(cmd_src1);
  assign push_cmd.src2 = MP_ADDR_W'(cmd_src2);
  assign push_cmd.dst  = MP_ADDR_W'(cmd_dst);

  maxpool_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef MAXPOOL_MIN_EN
  assign illegal = 1'b0;
`else
  assign illegal = (head.op == OP_MIN2);
`endif

  // A same-cycle push counts, so an idle engine starts RD the cycle after accept.
  assign avail = !empty || push;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      ST_IDLE: if (avail) state_nx = ST_RD;
      ST_RD: begin
        pop = 1'b1;
        if (illegal)
          state_nx = ((level > (PTR_W+1)'(1)) || push) ? ST_RD : ST_IDLE;
        else
          state_nx = ST_CMP;
      end
      ST_CMP:  state_nx = ST_WB;
      ST_WB:   state_nx = avail ? ST_RD : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign rf_raddr1   = (state == ST_RD && !illegal) ? ADDR_W'(head.src1) : raddr1_q;
  assign rf_raddr2   = (state == ST_RD && !illegal) ? ADDR_W'(head.src2) : raddr2_q;
  assign err_illegal = (state == ST_RD) && illegal;
  assign rf_we       = (state == ST_WB) && (op_q != OP_ACC);
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign busy        = (state != ST_IDLE) || !empty;

  // Per-lane compare; ties resolve to the src1 (or accumulator) value.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] a, b, acc, mx, amx;
    assign a   = $signed(rf_rdata1[i*DATA_W +: DATA_W]);
    assign b   = $signed(rf_rdata2[i*DATA_W +: DATA_W]);
    assign acc = $signed(acc_q[i]);
    assign mx  = (a >= b) ? a : b;
    assign amx = (acc >= mx) ? acc : mx;
`ifdef MAXPOOL_MIN_EN
    logic signed [DATA_W-1:0] mn;
    assign mn     = (a <= b) ? a : b;
    assign res[i] = (op_q == OP_MIN2) ? mn :
                    (op_q == OP_MAX2 || !acc_valid) ? mx : amx;
`else
    assign res[i] = (op_q == OP_MAX2 || !acc_valid) ? mx : amx;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_MAX2;
      dst_q     <= '0;
      raddr1_q  <= '0;
      raddr2_q  <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      acc_valid <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_RD: begin
          op_q  <= head.op;
          dst_q <= ADDR_W'(head.dst);
          if (!illegal) begin
            raddr1_q <= ADDR_W'(head.src1);
            raddr2_q <= ADDR_W'(head.src2);
          end
        end
        ST_CMP: begin
          if (op_q == OP_ACC) begin
            acc_q     <= res;
            acc_valid <= 1'b1;
          end else begin
            waddr_q <= dst_q;
            wdata_q <= res;
            if (op_q == OP_FLUSH) begin
              acc_q     <= '0;
              acc_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool_unit.sv
// Directed bench for maxpool_unit with a registered-read register file model
// and a write monitor that logs address, data and cycle of every rf_we pulse.
module tb_maxpool_unit;

  localparam logic [1:0] MAX2 = 2'b00, MIN2 = 2'b01, ACC = 2'b10, FLUSH = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [63:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_we, busy, err_illegal;

  maxpool_unit dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  logic [63:0] rf [32];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [63:0] pl_data = '0;
  int          cyc = 0, n_wr = 0, n_ill = 0;
  int          wa_q[$], wc_q[$];
  logic [63:0] wd_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rf_rdata1 <= rf[rf_raddr1];
    rf_rdata2 <= rf[rf_raddr2];
    if (pl_we) rf[pl_addr] <= pl_data;
    if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
      wa_q.push_back(int'(rf_waddr));
      wd_q.push_back(rf_wdata);
      wc_q.push_back(cyc);
      n_wr <= n_wr + 1;
    end
    if (err_illegal) n_ill <= n_ill + 1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] vec(input int l0, input int l1, input int l2, input int l3);
    return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  task automatic preload(input int a, input logic [63:0] d);
    pl_we = 1'b1; pl_addr = 5'(a); pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [1:0] op, input int s1, input int s2, input int d, output int t);
    int k = 0;
    cmd_valid = 1'b1; cmd_op = op;
    cmd_src1 = 5'(s1); cmd_src2 = 5'(s2); cmd_dst = 5'(d);
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) chk("push_timeout", 64'(cmd_ready), 64'd1);
    t = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    chk("idle", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic exp_wr(input string tag, input int a, input logic [63:0] d);
    if (wa_q.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_addr"}, 64'(wa_q.pop_front()), 64'(a));
      chk({tag, "_data"}, wd_q.pop_front(), d);
      void'(wc_q.pop_front());
    end
  endtask

  initial begin
    int t, w0, c0, i0;
    int wcyc[6];
    repeat (3) @(negedge clk);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_busy_in", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    chk("rst_raddr1", 64'(rf_raddr1), 64'd0);
    chk("rst_raddr2", 64'(rf_raddr2), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);

    preload(1, vec(5, -3, 7, 0));
    preload(2, vec(2, 4, -8, 0));
    preload(4, vec(100, 1, 2, 3));
    preload(5, vec(-1, -2, -3, -4));
    preload(6, vec(50, 9, -9, 0));

    // MAX2 with latency check
    w0 = n_wr;
    push(MAX2, 1, 2, 3, t);
    wait_idle();
    chk("max2_nwr", 64'(n_wr - w0), 64'd1);
    chk("max2_cyc", 64'(wc_q[0]), 64'(t + 3));
    exp_wr("max2", 3, vec(5, 4, 7, 0));

    // MIN2: legal only with the macro
    w0 = n_wr; i0 = n_ill;
    push(MIN2, 1, 2, 8, t);
    wait_idle();
`ifdef MAXPOOL_MIN_EN
    chk("min2_nwr", 64'(n_wr - w0), 64'd1);
    chk("min2_ill", 64'(n_ill - i0), 64'd0);
    exp_wr("min2", 8, vec(2, -3, -8, 0));
`else
    chk("min2_nwr", 64'(n_wr - w0), 64'd0);
    chk("min2_ill", 64'(n_ill - i0), 64'd1);
`endif

    // Pooling window across two ACCs and a FLUSH, then a bare FLUSH
    w0 = n_wr;
    push(ACC, 1, 2, 31, t);
    push(ACC, 4, 5, 30, t);
    wait_idle();
    chk("acc_nwr", 64'(n_wr - w0), 64'd0);
    push(FLUSH, 6, 6, 7, t);
    wait_idle();
    chk("flush_nwr", 64'(n_wr - w0), 64'd1);
    exp_wr("window", 7, vec(100, 9, 7, 3));
    push(FLUSH, 6, 6, 9, t);
    wait_idle();
    exp_wr("flush_bare", 9, vec(50, 9, -9, 0));

    // Backpressure: one leading command then five back-to-back
    w0 = n_wr;
    push(MAX2, 1, 2, 10, t);
    for (int k = 1; k <= 5; k++) push(MAX2, 1, 2, 10 + k, t);
    chk("bp_ready_low", 64'(cmd_ready), 64'd0);
    wait_idle();
    chk("bp_nwr", 64'(n_wr - w0), 64'd6);
    for (int k = 0; k < 6; k++) begin
      wcyc[k] = (wc_q.size() > 0) ? wc_q[0] : 0;
      exp_wr($sformatf("bp%0d", k), 10 + k, vec(5, 4, 7, 0));
    end
    for (int k = 1; k < 6; k++)
      chk($sformatf("bp_gap%0d", k), 64'(wcyc[k] - wcyc[k-1]), 64'd3);

    // RAW chain through r3
    preload(0, vec(-1, 10, -1, -1));
    preload(3, vec(0, 0, 0, 0));
    push(MAX2, 1, 2, 3, t);
    push(MAX2, 3, 0, 4, t);
    wait_idle();
    exp_wr("raw1", 3, vec(5, 4, 7, 0));
    exp_wr("raw2", 4, vec(5, 10, 7, 0));

    // Reset while a FLUSH is in CMP, with the accumulator primed
    push(ACC, 1, 2, 0, t);
    wait_idle();
    w0 = n_wr;
    push(FLUSH, 6, 6, 20, t);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", 64'(rf_we), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("rst_mid_nwr", 64'(n_wr - w0), 64'd0);
    c0 = cyc;
    push(FLUSH, 6, 6, 21, t);
    wait_idle();
    chk("post_rst_nwr", 64'(n_wr - w0), 64'd1);
    exp_wr("post_rst_flush", 21, vec(50, 9, -9, 0));
    chk("post_rst_time", 64'(cyc - c0 < 100), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
